// File: rtl/frame_scan_ctrl.sv
// Raster scan controller: reads one frame from a 1-cycle-latency RAM and streams it out
// over a valid/ready pixel port. Define FRAME_SCAN_ABORT_EN to add an abort input.
module frame_scan_ctrl #(
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 180,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 3,
    parameter int X_W     = 9,
    parameter int Y_W     = 8
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic              busy,
`ifdef FRAME_SCAN_ABORT_EN
    output logic              done,
    input  logic              abort
`else
    output logic              done
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [X_W-1:0]    LAST_X    = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(FRAME_H - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_s;
    logic [X_W-1:0]      x_r;
    logic [X_W-1:0]      x_s;
    logic [Y_W-1:0]      y_r;
    logic [Y_W-1:0]      y_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                done_r;
    logic                abort_s;
    logic                last_s;

`ifdef FRAME_SCAN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // The last pixel is identified by both coordinates so the counters can never run past the frame.
    assign last_s = (x_r == LAST_X) && (y_r == LAST_Y) && (addr_r == LAST_ADDR);

    // Next-state and next-coordinate decode.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        x_s     = x_r;
        y_s     = y_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    addr_s  = {ADDR_W{1'b0}};
                    x_s     = {X_W{1'b0}};
                    y_s     = {Y_W{1'b0}};
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            HOLD: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else if (out_ready) begin
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        addr_s  = addr_r + ADDR_W'(1);
                        if (x_r == LAST_X) begin
                            x_s = {X_W{1'b0}};
                            y_s = y_r + Y_W'(1);
                        end else begin
                            x_s = x_r + X_W'(1);
                            y_s = y_r;
                        end
                        state_s = READ;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            x_r         <= {X_W{1'b0}};
            y_r         <= {Y_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            x_r         <= x_s;
            y_r         <= y_s;
            if (state_s == READ) begin
                mem_addr_r <= addr_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            // RAM data for the address presented in READ is valid during WAIT.
            if (state_r == WAIT) begin
                out_data_r <= mem_q;
            end else begin
                out_data_r <= out_data_r;
            end
            out_valid_r <= (state_s == HOLD);
            busy_r      <= (state_s == READ) || (state_s == WAIT) || (state_s == HOLD);
            done_r      <= (state_s == DONE);
        end
    end

    assign mem_addr  = mem_addr_r;
    assign out_data  = out_data_r;
    assign out_x     = x_r;
    assign out_y     = y_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed bench for frame_scan_ctrl on a reduced 320x20 frame with a RAM returning addr[2:0].
module tb_frame_scan_ctrl;

    localparam int FW   = 320;
    localparam int FH   = 20;
    localparam int NPIX = FW * FH;

    logic        clock;
    logic        resetN;
    logic        start;
    logic [15:0] mem_addr;
    logic [2:0]  mem_q;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_data;
    logic [8:0]  out_x;
    logic [7:0]  out_y;
    logic        busy;
    logic        done;
    logic        abort;

    int vec_cnt;
    int err_cnt;

    frame_scan_ctrl #(
        .FRAME_W(FW),
        .FRAME_H(FH),
        .ADDR_W (16),
        .DATA_W (3),
        .X_W    (9),
        .Y_W    (8)
    ) dut (
        .clock    (clock),
        .resetN   (resetN),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_q    (mem_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_x    (out_x),
        .out_y    (out_y),
        .busy     (busy),
`ifdef FRAME_SCAN_ABORT_EN
        .done     (done),
        .abort    (abort)
`else
        .done     (done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM with one cycle of read latency; content is the low address bits.
    always @(posedge clock) mem_q <= mem_addr[2:0];

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one frame; stop_at >= 0 interrupts it in HOLD of that pixel by reset or abort.
    task automatic run_frame(input int stall, input bit poke, input int stop_at, input bit use_abort);
        int  n;
        int  cyc;
        int  done_cnt;
        int  stall_left;
        bit  seen_valid;
        bit  seen_done;
        n = 0; done_cnt = 0; stall_left = stall; seen_valid = 1'b0; seen_done = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; cyc = 0;
        check_vec("busy_after_start", 32'(busy), 32'd1);
        check_vec("valid_in_read", 32'(out_valid), 32'd0);
        while (!seen_done && cyc < 3 * NPIX + stall + 50) begin
            start = 1'b0; out_ready = 1'b1;
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check_vec("first_valid_latency", 32'(cyc), 32'd2);
                end
                if (n == stop_at) begin
                    if (use_abort) begin
`ifdef FRAME_SCAN_ABORT_EN
                        abort = 1'b1;
                        tick();
                        abort = 1'b0;
                        check_vec("abort_valid", 32'(out_valid), 32'd0);
                        check_vec("abort_busy", 32'(busy), 32'd0);
                        check_vec("abort_done", 32'(done), 32'd0);
                        check_vec("abort_not_accepted", 32'(mem_addr), 32'(stop_at));
                        repeat (5) begin
                            tick();
                            check_vec("abort_idle", 32'({busy, out_valid, done}), 32'd0);
                        end
`endif
                    end else begin
                        #2 resetN = 1'b0;
                        #1;
                        check_vec("rst_busy", 32'(busy), 32'd0);
                        check_vec("rst_valid", 32'(out_valid), 32'd0);
                        check_vec("rst_done", 32'(done), 32'd0);
                        check_vec("rst_addr", 32'(mem_addr), 32'd0);
                        check_vec("rst_xy", 32'({out_x, out_y}), 32'd0);
                    end
                    return;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    check_vec("stall_x", 32'(out_x), 32'd0);
                    check_vec("stall_y", 32'(out_y), 32'd0);
                    check_vec("stall_data", 32'(out_data), 32'd0);
                    check_vec("stall_addr", 32'(mem_addr), 32'd0);
                end else begin
                    check_vec("pix_x", 32'(out_x), 32'(n % FW));
                    check_vec("pix_y", 32'(out_y), 32'(n / FW));
                    check_vec("pix_data", 32'(out_data), 32'(n % 8));
                    if (n == NPIX - 1) check_vec("last_addr", 32'(mem_addr), 32'(NPIX - 1));
                    if (poke && n == 100) start = 1'b1;
                    n++;
                end
            end
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
                check_vec("done_cycle", 32'(cyc), 32'(3 * NPIX + stall));
                check_vec("pixels_accepted", 32'(n), 32'(NPIX));
                check_vec("busy_in_done", 32'(busy), 32'd0);
                if (poke) start = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check_vec("done_seen", 32'(seen_done), 32'd1);
        check_vec("post_done_pulse", 32'(done), 32'd0);
        check_vec("post_done_busy", 32'(busy), 32'd0);
        repeat (6) begin
            tick();
            if (done) done_cnt++;
        end
        check_vec("done_count", 32'(done_cnt), 32'd1);
        check_vec("no_restart", 32'({busy, out_valid}), 32'd0);
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        resetN = 1'b0; start = 1'b0; out_ready = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check_vec("reset_valid", 32'(out_valid), 32'd0);
        check_vec("reset_busy", 32'(busy), 32'd0);
        check_vec("reset_done", 32'(done), 32'd0);
        check_vec("reset_addr", 32'(mem_addr), 32'd0);
        check_vec("reset_data", 32'(out_data), 32'd0);
        check_vec("reset_x", 32'(out_x), 32'd0);
        check_vec("reset_y", 32'(out_y), 32'd0);
        resetN = 1'b1;
        repeat (4) tick();
        check_vec("idle_no_start", 32'({busy, out_valid, done}), 32'd0);

        run_frame(0, 1'b0, -1, 1'b0);
        run_frame(10, 1'b1, -1, 1'b0);

        run_frame(0, 1'b0, 5000, 1'b0);
        repeat (2) tick();
        resetN = 1'b1;
        repeat (10) begin
            tick();
            check_vec("after_reset_idle", 32'({busy, out_valid, done}), 32'd0);
        end

`ifdef FRAME_SCAN_ABORT_EN
        run_frame(0, 1'b0, 200, 1'b1);
        run_frame(0, 1'b0, 3, 1'b0);
        repeat (2) tick();
        resetN = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
